// File: rtl/axi4_wr_burst_master.sv
// Single-outstanding AXI4 INCR write-burst initiator: command in, AW/W/B out, done pulse back.
// Optional macro AXI4_WR_BURST_MASTER_BID_CHECK_EN turns a BID/AWID mismatch into SLVERR.
module axi4_wr_burst_master #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [7:0]                    cmd_len,
  input  logic [AXI_ID_WIDTH-1:0]       cmd_id,
  input  logic                          wdat_valid,
  output logic                          wdat_ready,
  input  logic [AXI_DATA_WIDTH-1:0]     wdat_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wdat_strb,
  output logic                          done_valid,
  output logic [1:0]                    done_resp,
  output logic [AXI_ID_WIDTH-1:0]       done_id,
  output logic [AXI_ID_WIDTH-1:0]       AWID,
  output logic [AXI_ADDRESS_WIDTH-1:0]  AWADDR,
  output logic [7:0]                    AWLEN,
  output logic [2:0]                    AWSIZE,
  output logic [1:0]                    AWBURST,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]     WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
  output logic                          WLAST,
  output logic                          WVALID,
  input  logic                          WREADY,
  input  logic [AXI_ID_WIDTH-1:0]       BID,
  input  logic [1:0]                    BRESP,
  input  logic                          BVALID,
  output logic                          BREADY
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // ADDR  | AW channel presented, waiting for AWREADY
  // DATA  | beats passed through to W until the WLAST handshake
  // RESP  | BREADY high, waiting for the write response
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AXI_ADDRESS_WIDTH-1:0] ADDR_MASK = {AXI_ADDRESS_WIDTH{1'b1}} << ADDR_LSB;

  state_t     state, state_next;
  logic [7:0] beat_cnt;
  logic       cmd_fire, w_fire, b_fire;
  logic [1:0] resp_eff;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign w_fire   = WVALID && WREADY;
  assign b_fire   = BVALID && BREADY;

  assign AWSIZE  = 3'(ADDR_LSB);
  assign AWBURST = 2'b01;

  assign WVALID     = (state == DATA) && wdat_valid;
  assign wdat_ready = (state == DATA) && WREADY;
  assign WDATA      = wdat_data;
  assign WSTRB      = wdat_strb;
  assign WLAST      = (state == DATA) && (beat_cnt == AWLEN);
  assign BREADY     = (state == RESP);

`ifdef AXI4_WR_BURST_MASTER_BID_CHECK_EN
  assign resp_eff = (BID != AWID) ? 2'b10 : BRESP;
`else
  logic bid_unused;
  assign bid_unused = ^BID;
  assign resp_eff   = BRESP;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmd_fire)         state_next = ADDR;
      ADDR: if (AWREADY)          state_next = DATA;
      DATA: if (w_fire && WLAST)  state_next = RESP;
      RESP: if (BVALID)           state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Handshake-facing flags are registered from the next state so they line up with it.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cmd_ready  <= 1'b0;
      AWVALID    <= 1'b0;
      done_valid <= 1'b0;
      done_resp  <= '0;
      done_id    <= '0;
      AWID       <= '0;
      AWADDR     <= '0;
      AWLEN      <= '0;
      beat_cnt   <= '0;
    end else begin
      cmd_ready  <= (state_next == IDLE);
      AWVALID    <= (state_next == ADDR);
      done_valid <= b_fire;
      if (cmd_fire) begin
        AWID     <= cmd_id;
        AWADDR   <= cmd_addr & ADDR_MASK;
        AWLEN    <= cmd_len;
        beat_cnt <= '0;
      end else if ((state == DATA) && w_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (b_fire) begin
        done_resp <= resp_eff;
        done_id   <= AWID;
      end
    end
  end

endmodule

// File: tb/tb_axi4_wr_burst_master.sv
// Directed bench for axi4_wr_burst_master: a table of bursts driven through a scripted slave.
module tb_axi4_wr_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat_data;
  logic [3:0]  wdat_strb;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [3:0]  done_id;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  axi4_wr_burst_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .wdat_strb(wdat_strb),
    .done_valid(done_valid), .done_resp(done_resp), .done_id(done_id),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

`ifdef AXI4_WR_BURST_MASTER_BID_CHECK_EN
  localparam logic [1:0] BID_ERR_RESP = 2'b10;
`else
  localparam logic [1:0] BID_ERR_RESP = 2'b00;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [31:0] data0;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    int          aw_stall;
    bit          wready_alt;
    bit          wvalid_gap;
    int          abort_beat;
    logic [31:0] exp_awaddr;
    logic [1:0]  exp_resp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic run_burst(input vec_t v);
    int guard;
    int beat;
    int cyc;
    guard = 0;
    @(negedge ACLK);
    while (!cmd_ready && guard < 20) begin
      @(negedge ACLK);
      guard++;
    end
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = v.len; cmd_id = v.id;
    step();
    cmd_valid = 1'b0;
    // stray W beat and B response while the address phase is pending
    wdat_valid = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b11; BID = v.id;
    for (int i = 0; i <= v.aw_stall; i++) begin
      AWREADY = (i == v.aw_stall);
      @(negedge ACLK);
      chk("awvalid", AWVALID, 1);
      chk("awaddr", AWADDR, v.exp_awaddr);
      chk("awlen", AWLEN, v.len);
      chk("awid", AWID, v.id);
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("wvalid_in_addr", WVALID, 0);
      chk("wdat_ready_in_addr", wdat_ready, 0);
      chk("bready_in_addr", BREADY, 0);
      step();
    end
    chk("awsize", AWSIZE, 2);
    chk("awburst", AWBURST, 1);
    AWREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(v.len) && cyc < 4000) begin
      if (v.abort_beat >= 0 && beat == v.abort_beat) break;
      wdat_valid = v.wvalid_gap ? (cyc % 3 != 2) : 1'b1;
      WREADY     = v.wready_alt ? (cyc % 2 == 0) : 1'b1;
      wdat_data  = v.data0 + 32'(beat);
      wdat_strb  = 4'hF - 4'(beat % 4);
      @(negedge ACLK);
      if (cyc == 0) chk("awvalid_dropped", AWVALID, 0);
      chk("wvalid_pass", WVALID, wdat_valid);
      chk("wdat_ready_pass", wdat_ready, WREADY);
      if (WVALID && WREADY) begin
        chk("wdata", WDATA, v.data0 + 32'(beat));
        chk("wstrb", WSTRB, 4'hF - 4'(beat % 4));
        chk("wlast", WLAST, beat == int'(v.len));
        beat++;
      end
      step();
      cyc++;
    end
    if (v.abort_beat >= 0) begin
      wdat_valid = 1'b1; WREADY = 1'b1;
      ARESETn = 1'b0;
      #1;
      chk("rst_awvalid", AWVALID, 0);
      chk("rst_wvalid", WVALID, 0);
      chk("rst_bready", BREADY, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      step();
      ARESETn = 1'b1; wdat_valid = 1'b0; WREADY = 1'b0;
      @(negedge ACLK);
      chk("cmd_ready_held_after_release", cmd_ready, 0);
      @(negedge ACLK);
      chk("cmd_ready_after_release", cmd_ready, 1);
      chk("no_done_after_abort", done_valid, 0);
      return;
    end
    chk("beat_count", beat, int'(v.len) + 1);
    wdat_valid = 1'b1; WREADY = 1'b1;
    @(negedge ACLK);
    chk("wvalid_in_resp", WVALID, 0);
    chk("wdat_ready_in_resp", wdat_ready, 0);
    chk("bready", BREADY, 1);
    chk("done_early", done_valid, 0);
    step();
    wdat_valid = 1'b0; WREADY = 1'b0;
    BVALID = 1'b1; BRESP = v.bresp; BID = v.bid;
    step();
    BVALID = 1'b0; BRESP = 2'b11;
    @(negedge ACLK);
    chk("done_valid", done_valid, 1);
    chk("done_resp", done_resp, v.exp_resp);
    chk("done_id", done_id, v.id);
    chk("cmd_ready_with_done", cmd_ready, 1);
    chk("bready_after_b", BREADY, 0);
    step();
    @(negedge ACLK);
    chk("done_one_cycle", done_valid, 0);
  endtask

  vec_t vecs[7];

  initial begin
    //            addr        len    id    data0         bresp  bid   stall alt gap abort exp_awaddr    exp_resp
    vecs[0] = '{32'h100,     8'd0,  4'd3, 32'hDEADBEEF, 2'b00, 4'd3, 0,    0,  0,  -1,   32'h100,      2'b00};
    vecs[1] = '{32'h200,     8'd3,  4'd1, 32'h1,        2'b00, 4'd1, 0,    1,  1,  -1,   32'h200,      2'b00};
    vecs[2] = '{32'h300,     8'd1,  4'd2, 32'hA0,       2'b00, 4'd2, 5,    0,  0,  -1,   32'h300,      2'b00};
    vecs[3] = '{32'h103,     8'd0,  4'd7, 32'h55,       2'b10, 4'd7, 0,    0,  0,  -1,   32'h100,      2'b10};
    vecs[4] = '{32'h400,     8'd3,  4'd3, 32'h10,       2'b00, 4'd3, 0,    0,  0,  2,    32'h400,      2'b00};
    vecs[5] = '{32'h500,     8'd1,  4'd3, 32'h20,       2'b00, 4'd5, 0,    0,  0,  -1,   32'h500,      BID_ERR_RESP};
    vecs[6] = '{32'h2000,    8'd255,4'hF, 32'h1000,     2'b01, 4'hF, 1,    1,  0,  -1,   32'h2000,     2'b01};

    ARESETn = 1'b0;
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wdat_valid = 0; wdat_data = 0; wdat_strb = 0;
    AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_awvalid", AWVALID, 0);
    chk("reset_bready", BREADY, 0);
    chk("reset_done_valid", done_valid, 0);
    chk("reset_done_resp", done_resp, 0);
    chk("reset_done_id", done_id, 0);
    chk("reset_awaddr", AWADDR, 0);
    chk("reset_awlen", AWLEN, 0);
    chk("reset_awid", AWID, 0);
    chk("reset_wvalid", WVALID, 0);
    step();
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("cmd_ready_first_cycle", cmd_ready, 0);
    @(negedge ACLK);
    chk("cmd_ready_first_edge", cmd_ready, 1);

    for (int k = 0; k < 7; k++) run_burst(vecs[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
